ps2_mouse_interface: RTL and testbench

PS2_MOUSE_INTERFACE -- requirements
Module: ps2_mouse_interface

---
 rtl/ps2_mouse_interface_if.sv | 25 ++
 rtl/ps2_mouse_interface.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_mouse_interface.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_interface_if.sv
// Decoded mouse packet bundle: button states, signed X/Y movement and a
// one-cycle ready strobe that marks a freshly accepted packet.
interface ps2_mouse_interface_if;
    logic              button_left;
    logic              button_right;
    logic signed [8:0] delta_x;
    logic signed [8:0] delta_y;
    logic              ready;

    modport master (
        output button_left,
        output button_right,
        output delta_x,
        output delta_y,
        output ready
    );

    modport slave (
        input button_left,
        input button_right,
        input delta_x,
        input delta_y,
        input ready
    );
endinterface

// File: rtl/ps2_mouse_interface.sv
// PS/2 mouse host: enables streaming mode (0xF4), waits for the 0xFA
// acknowledge, then decodes 3-byte movement packets. Both PS/2 pins are
// open-drain: the block only ever pulls them low or releases them.
module ps2_mouse_interface #(
    parameter int FILTER_LENGTH  = 8,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                   clock,
    input  logic                   reset,
    inout  wire                    mouse_clock,
    inout  wire                    mouse_data,
    ps2_mouse_interface_if.master  pkt
);

    localparam int FW = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] ENABLE_CMD    = 8'hF4;
    localparam logic       ENABLE_PARITY = ~(^ENABLE_CMD);
    localparam logic [7:0] ACK_BYTE      = 8'hFA;

    typedef enum logic [2:0] {
        S_INHIBIT,
        S_REQUEST,
        S_SEND,
        S_ACK_WAIT,
        S_WAIT_ACK_BYTE,
        S_STREAM
    } state_t;

    // Overflowed axes report no movement; otherwise sign-extend the 9-bit field.
    function automatic logic signed [8:0] apply_overflow(input logic ovf,
                                                         input logic sign,
                                                         input logic [7:0] low);
        return ovf ? 9'sd0 : $signed({sign, low});
    endfunction

    logic          mclk_p0, mclk_p1;
    logic          mdat_p0, mdat_p1;
    logic          filt_level;
    logic [FW-1:0] filt_cnt;
    logic          fall_p2;

    state_t        state;
    logic          clk_low;
    logic          dat_low;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    send_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    rx_sr;
    logic [1:0]    byte_idx;
    logic [5:0]    hdr;       // {Yovf, Xovf, Ysign, Xsign, right, left}
    logic [7:0]    byte1;

    logic       rx_active;
    logic       frame_done;
    logic       frame_ok;
    logic [7:0] rx_byte;
    logic       timeout_active;
    logic       timed_out;

    assign mouse_clock = clk_low ? 1'b0 : 1'bz;
    assign mouse_data  = dat_low ? 1'b0 : 1'bz;

    assign rx_active  = (state == S_WAIT_ACK_BYTE) || (state == S_STREAM);
    assign rx_byte    = rx_sr[8:1];
    assign frame_done = rx_active && fall_p2 && (bit_cnt == 4'd10);
    // rx_sr holds start in [0], data in [8:1], parity in [9]; stop is the live sample.
    assign frame_ok   = frame_done && !rx_sr[0] && (^rx_sr[9:1]) && mdat_p1;

    // A silent bus is only an error while a transaction is under way.
    assign timeout_active = (state == S_REQUEST) || (state == S_SEND) ||
                            (state == S_ACK_WAIT) || (state == S_WAIT_ACK_BYTE) ||
                            ((state == S_STREAM) && ((bit_cnt != 4'd0) || (byte_idx != 2'd0)));
    assign timed_out = timeout_active && !fall_p2 && (to_cnt == TW'(TIMEOUT_CYCLES));

    // Synchronize both pins and debounce mouse_clock; emit a pulse on each filtered falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mclk_p0    <= 1'b1;
            mclk_p1    <= 1'b1;
            mdat_p0    <= 1'b1;
            mdat_p1    <= 1'b1;
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fall_p2    <= 1'b0;
        end else begin
            mclk_p0 <= mouse_clock;
            mclk_p1 <= mclk_p0;
            mdat_p0 <= mouse_data;
            mdat_p1 <= mdat_p0;
            fall_p2 <= 1'b0;
            if (mclk_p1 == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LENGTH - 1)) begin
                filt_level <= mclk_p1;
                filt_cnt   <= '0;
                fall_p2    <= filt_level;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // Control FSM, host-to-device transmitter, frame receiver and packet assembly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_INHIBIT;
            clk_low          <= 1'b1;
            dat_low          <= 1'b0;
            inh_cnt          <= '0;
            to_cnt           <= '0;
            send_cnt         <= '0;
            bit_cnt          <= '0;
            rx_sr            <= '0;
            byte_idx         <= '0;
            hdr              <= '0;
            byte1            <= '0;
            pkt.button_left  <= 1'b0;
            pkt.button_right <= 1'b0;
            pkt.delta_x      <= '0;
            pkt.delta_y      <= '0;
            pkt.ready        <= 1'b0;
        end else begin
            pkt.ready <= 1'b0;

            if (fall_p2 || !timeout_active) begin
                to_cnt <= '0;
            end else if (!timed_out) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (rx_active && fall_p2) begin
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                end else begin
                    rx_sr   <= {mdat_p1, rx_sr[9:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            case (state)
                S_INHIBIT: begin
                    clk_low  <= 1'b1;
                    dat_low  <= 1'b0;
                    bit_cnt  <= '0;
                    byte_idx <= '0;
                    if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        inh_cnt <= '0;
                        clk_low <= 1'b0;
                        dat_low <= 1'b1;   // start bit goes out as the clock is released
                        state   <= S_REQUEST;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                S_REQUEST: begin
                    send_cnt <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (fall_p2) begin
                        if (send_cnt < 4'd8) begin
                            dat_low  <= ~ENABLE_CMD[send_cnt[2:0]];
                            send_cnt <= send_cnt + 1'b1;
                        end else if (send_cnt == 4'd8) begin
                            dat_low  <= ~ENABLE_PARITY;
                            send_cnt <= send_cnt + 1'b1;
                        end else begin
                            dat_low <= 1'b0;
                            state   <= S_ACK_WAIT;
                        end
                    end
                end
                S_ACK_WAIT: begin
                    if (fall_p2 && !mdat_p1) begin
                        bit_cnt <= '0;
                        state   <= S_WAIT_ACK_BYTE;
                    end
                end
                S_WAIT_ACK_BYTE: begin
                    if (frame_done) begin
                        if (frame_ok && (rx_byte == ACK_BYTE)) begin
                            state <= S_STREAM;
                        end else begin
                            state   <= S_INHIBIT;
                            clk_low <= 1'b1;
                            inh_cnt <= '0;
                        end
                    end
                end
                S_STREAM: begin
                    clk_low <= 1'b0;
                    dat_low <= 1'b0;
                    if (frame_done) begin
                        if (!frame_ok) begin
                            byte_idx <= '0;
                        end else begin
                            case (byte_idx)
                                2'd0: begin
                                    // bit3 is always set in a header byte; anything else means we are out of sync
                                    if (rx_byte[3]) begin
                                        hdr      <= {rx_byte[7:4], rx_byte[1:0]};
                                        byte_idx <= 2'd1;
                                    end
                                end
                                2'd1: begin
                                    byte1    <= rx_byte;
                                    byte_idx <= 2'd2;
                                end
                                default: begin
                                    pkt.button_left  <= hdr[0];
                                    pkt.button_right <= hdr[1];
                                    pkt.delta_x      <= apply_overflow(hdr[4], hdr[2], byte1);
                                    pkt.delta_y      <= apply_overflow(hdr[5], hdr[3], rx_byte);
                                    pkt.ready        <= 1'b1;
                                    byte_idx         <= 2'd0;
                                end
                            endcase
                        end
                    end
                    if (timed_out) begin
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                    end
                end
                default: begin
                    state <= S_INHIBIT;
                end
            endcase

            // A stalled enable handshake restarts the whole sequence.
            if (timed_out && (state != S_STREAM)) begin
                state   <= S_INHIBIT;
                clk_low <= 1'b1;
                dat_low <= 1'b0;
                inh_cnt <= '0;
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_interface.sv
// Bench for ps2_mouse_interface: a PS/2 mouse device model drives the
// open-drain bus; packet expectations come from plain arithmetic on the
// bytes sent.
module tb_ps2_mouse_interface;

    localparam int FILT = 8;
    localparam int INH  = 300;
    localparam int TMO  = 1500;
    localparam int HP   = 25;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    wire mouse_clock;
    wire mouse_data;
    assign mouse_clock = dev_clk_low ? 1'b0 : 1'bz;
    assign mouse_data  = dev_dat_low ? 1'b0 : 1'bz;
    pullup (mouse_clock);
    pullup (mouse_data);

    ps2_mouse_interface_if pkt_if ();

    ps2_mouse_interface #(
        .FILTER_LENGTH (FILT),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mouse_clock(mouse_clock),
        .mouse_data (mouse_data),
        .pkt        (pkt_if)
    );

    always #10 clock = ~clock;

    int cmp = 0;
    int mis = 0;

    int         rdy_cnt  = 0;
    int         rdy_wide = 0;
    logic       rdy_prev = 1'b0;
    logic       cap_l = 1'b0, cap_r = 1'b0;
    logic [8:0] cap_dx = '0, cap_dy = '0;

    // ready monitor: counts pulses, latches the outputs seen with each pulse
    always @(negedge clock) begin
        rdy_prev <= pkt_if.ready;
        if (pkt_if.ready) begin
            rdy_cnt <= rdy_cnt + 1;
            cap_l   <= pkt_if.button_left;
            cap_r   <= pkt_if.button_right;
            cap_dx  <= pkt_if.delta_x;
            cap_dy  <= pkt_if.delta_y;
            if (rdy_prev) rdy_wide <= rdy_wide + 1;
        end
    end

    initial begin
        #(95000 * 20);
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    // movement value a mouse reports: signed 9-bit, zero on overflow
    function automatic logic [8:0] model_delta(input logic sign, input logic ovf,
                                               input logic [7:0] low);
        int v;
        v = int'(low);
        if (sign) v = v - 256;
        if (ovf)  v = 0;
        return v[8:0];
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // device-to-host frame; nbits < 11 leaves the frame unfinished
    task automatic dev_send_bits(input logic [7:0] b, input bit bad_par,
                                 input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock);
            dev_dat_low = ~fr[i];
            cycles(HP);
            dev_clk_low = 1'b1;
            cycles(HP);
            dev_clk_low = 1'b0;
        end
        cycles(1);
        dev_dat_low = 1'b0;
        cycles(2 * HP);
    endtask

    task automatic dev_send_packet(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2);
        dev_send_bits(b0, 1'b0, 1'b0, 11);
        dev_send_bits(b1, 1'b0, 1'b0, 11);
        dev_send_bits(b2, 1'b0, 1'b0, 11);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        cycles(5);
        cmp++; if (pkt_if.ready !== 1'b0) begin mis++; $display("FAIL reset_ready: got %b want 0", pkt_if.ready); end
        cmp++; if (pkt_if.button_left !== 1'b0) begin mis++; $display("FAIL reset_left: got %b want 0", pkt_if.button_left); end
        cmp++; if (pkt_if.button_right !== 1'b0) begin mis++; $display("FAIL reset_right: got %b want 0", pkt_if.button_right); end
        cmp++; if (pkt_if.delta_x !== 9'h000) begin mis++; $display("FAIL reset_dx: got %h want 000", pkt_if.delta_x); end
        cmp++; if (pkt_if.delta_y !== 9'h000) begin mis++; $display("FAIL reset_dy: got %h want 000", pkt_if.delta_y); end
        cmp++; if (mouse_clock !== 1'b0) begin mis++; $display("FAIL reset_clk_inhibit: got %b want 0", mouse_clock); end
        cmp++; if (mouse_data !== 1'b1) begin mis++; $display("FAIL reset_data_released: got %b want 1", mouse_data); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    // enable handshake as seen by the mouse; check_len measures the inhibit from reset release
    task automatic test_enable(input logic [7:0] ack, input bit check_len);
        int         n;
        bit         released;
        int         rdy0;
        logic [9:0] got;
        rdy0 = rdy_cnt;
        n = 0;
        released = 1'b0;
        while (!released && n <= 4 * INH) begin
            @(posedge clock);
            #1;
            n++;
            if (mouse_clock === 1'b1) released = 1'b1;
        end
        cmp++; if (!released) begin mis++; $display("FAIL enable_release: clock still low after %0d cycles, required release", n); return; end
        if (check_len) begin
            cmp++; if (n !== INH) begin mis++; $display("FAIL inhibit_len: got %0d cycles want %0d", n, INH); end
        end
        cmp++; if (mouse_data !== 1'b0) begin mis++; $display("FAIL request_data_low: got %b want 0", mouse_data); end
        for (int i = 0; i < 10; i++) begin
            cycles(HP);
            dev_clk_low = 1'b1;
            cycles(HP);
            got[i] = mouse_data;
            dev_clk_low = 1'b0;
        end
        cmp++; if (got[7:0] !== 8'hF4) begin mis++; $display("FAIL enable_cmd: got %h want f4", got[7:0]); end
        cmp++; if (got[8] !== 1'b0) begin mis++; $display("FAIL enable_parity: got %b want 0", got[8]); end
        cmp++; if (got[9] !== 1'b1) begin mis++; $display("FAIL enable_stop: got %b want 1", got[9]); end
        cycles(HP);
        dev_dat_low = 1'b1;
        cycles(HP);
        dev_clk_low = 1'b1;
        cycles(HP);
        dev_clk_low = 1'b0;
        cycles(1);
        dev_dat_low = 1'b0;
        cycles(2 * HP);
        dev_send_bits(ack, 1'b0, 1'b0, 11);
        cmp++; if (rdy_cnt !== rdy0) begin mis++; $display("FAIL enable_no_ready: got %0d pulses want 0", rdy_cnt - rdy0); end
    endtask

    task automatic test_valid_packet(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input string tag);
        int         rdy0;
        logic       el, er;
        logic [8:0] edx, edy;
        el  = b0[0];
        er  = b0[1];
        edx = model_delta(b0[4], b0[6], b1);
        edy = model_delta(b0[5], b0[7], b2);
        rdy0 = rdy_cnt;
        dev_send_packet(b0, b1, b2);
        cmp++; if (rdy_cnt - rdy0 !== 1) begin mis++; $display("FAIL %s_ready: got %0d pulses want 1", tag, rdy_cnt - rdy0); end
        cmp++; if (cap_l !== el) begin mis++; $display("FAIL %s_left: got %b want %b", tag, cap_l, el); end
        cmp++; if (cap_r !== er) begin mis++; $display("FAIL %s_right: got %b want %b", tag, cap_r, er); end
        cmp++; if (cap_dx !== edx) begin mis++; $display("FAIL %s_dx: got %h want %h", tag, cap_dx, edx); end
        cmp++; if (cap_dy !== edy) begin mis++; $display("FAIL %s_dy: got %h want %h", tag, cap_dy, edy); end
        cycles(20);
        cmp++; if (pkt_if.delta_x !== edx || pkt_if.delta_y !== edy) begin
            mis++; $display("FAIL %s_hold: got %h/%h want %h/%h", tag, pkt_if.delta_x, pkt_if.delta_y, edx, edy);
        end
    endtask

    task automatic test_directed;
        int rdy0;
        test_valid_packet(8'h29, 8'h05, 8'hFB, "pkt_basic");
        test_valid_packet(8'h58, 8'h10, 8'h20, "pkt_xovf");
        rdy0 = rdy_cnt;
        dev_send_bits(8'h00, 1'b0, 1'b0, 11);
        cmp++; if (rdy_cnt !== rdy0) begin mis++; $display("FAIL resync_discard: got %0d pulses want 0", rdy_cnt - rdy0); end
        test_valid_packet(8'h0A, 8'hFF, 8'h01, "pkt_resync");
    endtask

    task automatic test_random_packets;
        logic [7:0] b0, b1, b2;
        for (int k = 0; k < 6; k++) begin
            b0 = 8'($urandom) | 8'h08;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            test_valid_packet(b0, b1, b2, "rand");
        end
    endtask

    task automatic test_parity_error;
        int rdy0;
        rdy0 = rdy_cnt;
        dev_send_bits(8'h09, 1'b0, 1'b0, 11);
        dev_send_bits(8'h33, 1'b1, 1'b0, 11);
        cmp++; if (rdy_cnt !== rdy0) begin mis++; $display("FAIL parity_no_ready: got %0d pulses want 0", rdy_cnt - rdy0); end
        test_valid_packet(8'h1B, 8'h80, 8'h7F, "after_parity");
    endtask

    task automatic test_stop_error;
        int rdy0;
        rdy0 = rdy_cnt;
        dev_send_bits(8'h09, 1'b0, 1'b0, 11);
        dev_send_bits(8'h44, 1'b0, 1'b0, 11);
        dev_send_bits(8'h0C, 1'b0, 1'b1, 11);
        cmp++; if (rdy_cnt !== rdy0) begin mis++; $display("FAIL stop_no_ready: got %0d pulses want 0", rdy_cnt - rdy0); end
        test_valid_packet(8'hB9, 8'h12, 8'h34, "after_stop");
    endtask

    // stall after a full byte 1, then stall in the middle of byte 1
    task automatic test_stall;
        int rdy0;
        for (int v = 0; v < 2; v++) begin
            rdy0 = rdy_cnt;
            dev_send_bits(8'h19, 1'b0, 1'b0, 11);
            dev_send_bits(8'h21, 1'b0, 1'b0, (v == 0) ? 11 : 5);
            cycles(2 * TMO);
            cmp++; if (mouse_clock !== 1'b1) begin mis++; $display("FAIL stall_clock_released: got %b want 1", mouse_clock); end
            cmp++; if (rdy_cnt !== rdy0) begin mis++; $display("FAIL stall_no_ready: got %0d pulses want 0", rdy_cnt - rdy0); end
            test_valid_packet(8'h2A, 8'h0E, 8'hF0, "after_stall");
        end
    endtask

    task automatic test_idle_no_timeout;
        int lows;
        lows = 0;
        for (int i = 0; i < 2 * TMO; i++) begin
            @(negedge clock);
            if (mouse_clock !== 1'b1 || mouse_data !== 1'b1) lows++;
        end
        cmp++; if (lows !== 0) begin mis++; $display("FAIL idle_pins_released: got %0d driven cycles want 0", lows); end
        test_valid_packet(8'h38, 8'hC0, 8'h40, "after_idle");
    endtask

    task automatic test_reset_mid_packet;
        dev_send_bits(8'h09, 1'b0, 1'b0, 11);
        dev_send_bits(8'h55, 1'b0, 1'b0, 4);
        @(negedge clock);
        reset = 1'b1;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        cycles(3);
        cmp++; if (pkt_if.delta_x !== 9'h000 || pkt_if.delta_y !== 9'h000) begin
            mis++; $display("FAIL midreset_delta: got %h/%h want 000/000", pkt_if.delta_x, pkt_if.delta_y);
        end
        cmp++; if (pkt_if.button_left !== 1'b0 || pkt_if.button_right !== 1'b0) begin
            mis++; $display("FAIL midreset_buttons: got %b%b want 00", pkt_if.button_right, pkt_if.button_left);
        end
        cmp++; if (mouse_clock !== 1'b0) begin mis++; $display("FAIL midreset_inhibit: got %b want 0", mouse_clock); end
        @(negedge clock);
        reset = 1'b0;
        test_enable(8'hFA, 1'b1);
        test_valid_packet(8'h09, 8'h03, 8'h02, "after_midreset");
    endtask

    task automatic test_nack;
        @(negedge clock);
        reset = 1'b1;
        cycles(3);
        @(negedge clock);
        reset = 1'b0;
        test_enable(8'hFE, 1'b1);
        cmp++; if (mouse_clock !== 1'b0) begin mis++; $display("FAIL nack_reinhibit: got %b want 0", mouse_clock); end
        test_enable(8'hFA, 1'b0);
        test_valid_packet(8'h29, 8'h05, 8'hFB, "after_nack");
    endtask

    task automatic test_ready_width;
        cmp++; if (rdy_wide !== 0) begin mis++; $display("FAIL ready_width: got %0d multi-cycle pulses want 0", rdy_wide); end
    endtask

    initial begin
        test_reset;
        test_enable(8'hFA, 1'b1);
        test_directed;
        test_random_packets;
        test_parity_error;
        test_stop_error;
        test_stall;
        test_idle_no_timeout;
        test_reset_mid_packet;
        test_nack;
        test_ready_width;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
